// File: rtl/tone_decoder.sv
// tone_decoder: measures the period of an external square-wave tone in
// system clocks, classifies it against the seven-note table (DO..XI) and
// reports a stable note code once LOCK_CNT consecutive periods agree.
module tone_decoder #(
    parameter logic [15:0] DO       = 16'd47750,
    parameter logic [15:0] RE       = 16'd42250,
    parameter logic [15:0] MI       = 16'd37900,
    parameter logic [15:0] FA       = 16'd37550,
    parameter logic [15:0] SO       = 16'd31850,
    parameter logic [15:0] LA       = 16'd28400,
    parameter logic [15:0] XI       = 16'd25400,
    parameter logic [15:0] TOL      = 16'd150,
    parameter logic [2:0]  LOCK_CNT = 3'd4,
    parameter logic [16:0] TIMEOUT  = 17'd100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tone_in,
    output logic [2:0]  note,
    output logic        note_valid,
    output logic        note_chg,
    output logic [16:0] period
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    // Note periods packed so a generate loop can index note k at slot k-1.
    localparam logic [7*16-1:0] NOTE_TBL = {XI, LA, SO, FA, MI, RE, DO};
    localparam logic [16:0]     TOL17    = {1'b0, TOL};

    logic        sync1_reg, sync2_reg, sync3_reg;
    logic        edge_reg;
    logic [16:0] cnt_reg, cnt_next;
    logic [1:0]  state_reg, state_next;
    logic [2:0]  cand_reg, cand_next;
    logic [2:0]  mcnt_reg, mcnt_next;
    logic [2:0]  note_reg, note_next;
    logic        valid_reg, valid_next;
    logic        chg_reg, chg_next;
    logic [16:0] period_reg, period_next;

    logic [6:0]  hit;
    logic [2:0]  class_code;
    logic [2:0]  mcnt_inc;
    logic        timeout;

    // Synchronise the asynchronous tone and detect its rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            sync3_reg <= 1'b0;
            edge_reg  <= 1'b0;
        end else begin
            sync1_reg <= tone_in;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
            edge_reg  <= sync2_reg & ~sync3_reg;
        end
    end

    // Per-note tolerance windows on the running count, unsigned 17-bit.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_win
            localparam logic [16:0] CENTER = {1'b0, NOTE_TBL[gi*16 +: 16]};
            localparam logic [16:0] LO     = (CENTER > TOL17) ? (CENTER - TOL17) : 17'd0;
            localparam logic [16:0] HI     = CENTER + TOL17;
            assign hit[gi] = (cnt_reg >= LO) && (cnt_reg <= HI);
        end
    endgenerate

    // Priority encode the window hits; the lowest note index wins an overlap.
    always_comb begin
        class_code = 3'd0;
        for (int k = 6; k >= 0; k--) begin
            if (hit[k]) begin
                class_code = 3'(k + 1);
            end
        end
    end

    assign mcnt_inc = mcnt_reg + 3'd1;
    assign timeout  = (cnt_reg == TIMEOUT) && (state_reg != ST_IDLE);

    // Period counter: reloads to 1 on the edge cycle so that on the next
    // edge cycle it holds exactly the number of clocks between the edges.
    always_comb begin
        if (edge_reg) begin
            cnt_next = 17'd1;
        end else if (cnt_reg != TIMEOUT) begin
            cnt_next = cnt_reg + 17'd1;
        end else begin
            cnt_next = cnt_reg;
        end
    end

    // Acquire/lock state machine; an edge takes precedence over a timeout.
    always_comb begin
        state_next  = state_reg;
        cand_next   = cand_reg;
        mcnt_next   = mcnt_reg;
        note_next   = note_reg;
        valid_next  = valid_reg;
        chg_next    = 1'b0;
        period_next = period_reg;

        if (edge_reg) begin
            if (state_reg != ST_IDLE) begin
                period_next = cnt_reg;
            end
            case (state_reg)
                ST_IDLE: begin
                    // First edge only starts timing.
                    state_next = ST_ACQUIRE;
                    cand_next  = 3'd0;
                    mcnt_next  = 3'd0;
                end
                ST_ACQUIRE: begin
                    if (class_code == 3'd0) begin
                        cand_next = 3'd0;
                        mcnt_next = 3'd0;
                    end else if (class_code == cand_reg) begin
                        mcnt_next = mcnt_inc;
                        if (mcnt_inc >= LOCK_CNT) begin
                            state_next = ST_LOCKED;
                            note_next  = class_code;
                            valid_next = 1'b1;
                            chg_next   = 1'b1;
                        end
                    end else begin
                        cand_next = class_code;
                        mcnt_next = 3'd1;
                    end
                end
                ST_LOCKED: begin
                    if (class_code != note_reg) begin
                        state_next = ST_ACQUIRE;
                        note_next  = 3'd0;
                        valid_next = 1'b0;
                        chg_next   = 1'b1;
                        cand_next  = class_code;
                        mcnt_next  = (class_code != 3'd0) ? 3'd1 : 3'd0;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end else if (timeout) begin
            state_next = ST_IDLE;
            cand_next  = 3'd0;
            mcnt_next  = 3'd0;
            if (state_reg == ST_LOCKED) begin
                note_next  = 3'd0;
                valid_next = 1'b0;
                chg_next   = 1'b1;
            end
        end
    end

    // Register counter, state and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= 17'd0;
            state_reg  <= ST_IDLE;
            cand_reg   <= 3'd0;
            mcnt_reg   <= 3'd0;
            note_reg   <= 3'd0;
            valid_reg  <= 1'b0;
            chg_reg    <= 1'b0;
            period_reg <= 17'd0;
        end else begin
            cnt_reg    <= cnt_next;
            state_reg  <= state_next;
            cand_reg   <= cand_next;
            mcnt_reg   <= mcnt_next;
            note_reg   <= note_next;
            valid_reg  <= valid_next;
            chg_reg    <= chg_next;
            period_reg <= period_next;
        end
    end

    assign note       = note_reg;
    assign note_valid = valid_reg;
    assign note_chg   = chg_reg;
    assign period     = period_reg;

endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: directed tone bursts with a scoreboard of expected
// note_chg events (note, valid, cycle); a monitor pops on every pulse.
// Note table is scaled down by 100 to keep the run short.
`timescale 1ns/1ps
module tb_tone_decoder;

    localparam logic [15:0] P_DO  = 16'd478;
    localparam logic [15:0] P_RE  = 16'd423;
    localparam logic [15:0] P_MI  = 16'd380;
    localparam logic [15:0] P_FA  = 16'd376;
    localparam logic [15:0] P_SO  = 16'd319;
    localparam logic [15:0] P_LA  = 16'd284;
    localparam logic [15:0] P_XI  = 16'd254;
    localparam logic [15:0] P_TOL = 16'd1;
    localparam int          TMO   = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tone_in = 1'b0;
    logic [2:0]  note;
    logic        note_valid;
    logic        note_chg;
    logic [16:0] period;

    typedef struct {
        logic [2:0] n;
        logic       v;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   last_rise = 0;
    int   checks = 0;
    int   errors = 0;

    tone_decoder #(
        .DO(P_DO), .RE(P_RE), .MI(P_MI), .FA(P_FA), .SO(P_SO), .LA(P_LA),
        .XI(P_XI), .TOL(P_TOL), .LOCK_CNT(3'd4), .TIMEOUT(17'(TMO))
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tone_in(tone_in),
        .note(note),
        .note_valid(note_valid),
        .note_chg(note_chg),
        .period(period)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One rising edge now, then hold for p clocks before returning.
    task automatic pulse(input int p, input bit chg, input logic [2:0] n, input logic v);
        if (chg) exp_q.push_back('{n: n, v: v, cyc: cyc + 4});
        last_rise = cyc;
        $display("edge at cycle %0d gap %0d expect_chg=%0d note=%0d", cyc, p, chg, n);
        tone_in = 1'b1;
        repeat (p / 2) @(negedge clk);
        tone_in = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    // n edges with gap p; if lk != 0 the 5th edge completes the lock.
    task automatic burst(input int p, input int n, input logic [2:0] lk);
        for (int i = 0; i < n; i++) begin
            pulse(p, (lk != 3'd0) && (i == 4), lk, 1'b1);
        end
    endtask

    // Hold the tone low past the timeout.
    task automatic silence(input bit chg);
        if (chg) exp_q.push_back('{n: 3'd0, v: 1'b0, cyc: last_rise + 4 + TMO});
        tone_in = 1'b0;
        while (cyc < last_rise + TMO + 12) @(negedge clk);
        $display("silence done at cycle %0d expect_chg=%0d", cyc, chg);
    endtask

    // Monitor: every note_chg pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (note_chg) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_chg", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("chg at cycle %0d note=%0d valid=%0d", cyc, note, note_valid);
                chk("chg_note", int'(note), int'(e.n));
                chk("chg_valid", int'(note_valid), int'(e.v));
                chk("chg_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_note", int'(note), 0);
        chk("rst_valid", int'(note_valid), 0);
        chk("rst_chg", int'(note_chg), 0);
        chk("rst_period", int'(period), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // DO lock on the 5th edge.
        burst(P_DO, 5, 3'd1);
        chk("do_note", int'(note), 1);
        chk("do_valid", int'(note_valid), 1);
        chk("do_period", int'(period), 478);
        silence(1'b1);

        // Tolerance edges: +1 locks, +2 never locks; same below.
        burst(479, 5, 3'd1);
        silence(1'b1);
        burst(480, 6, 3'd0);
        chk("tol_hi_note", int'(note), 0);
        chk("tol_hi_period", int'(period), 480);
        silence(1'b0);
        burst(477, 5, 3'd1);
        silence(1'b1);
        burst(476, 6, 3'd0);
        chk("tol_lo_note", int'(note), 0);
        silence(1'b0);

        // MI/FA separation and their midpoint.
        burst(P_FA, 5, 3'd4);
        silence(1'b1);
        burst(P_MI, 5, 3'd3);
        silence(1'b1);
        burst(378, 6, 3'd0);
        chk("mid_note", int'(note), 0);
        chk("mid_valid", int'(note_valid), 0);
        silence(1'b0);

        // Note switch SO -> LA.
        for (int i = 0; i < 4; i++) pulse(P_SO, 1'b0, 3'd0, 1'b0);
        pulse(P_LA, 1'b1, 3'd5, 1'b1);
        pulse(P_LA, 1'b1, 3'd0, 1'b0);
        pulse(P_LA, 1'b0, 3'd0, 1'b0);
        pulse(P_LA, 1'b0, 3'd0, 1'b0);
        pulse(P_LA, 1'b1, 3'd6, 1'b1);
        chk("sw_note", int'(note), 6);
        silence(1'b1);

        // XI silence, then one edge from IDLE must not update period.
        burst(P_XI, 5, 3'd7);
        silence(1'b1);
        chk("xi_idle_valid", int'(note_valid), 0);
        chk("xi_period", int'(period), 254);
        pulse(100, 1'b0, 3'd0, 1'b0);
        chk("idle_edge_period", int'(period), 254);
        silence(1'b0);

        // RE lock, glitch unlock, relock after four RE periods.
        for (int i = 0; i < 4; i++) pulse(P_RE, 1'b0, 3'd0, 1'b0);
        pulse(20, 1'b1, 3'd2, 1'b1);
        pulse(P_RE, 1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) pulse(P_RE, 1'b0, 3'd0, 1'b0);
        pulse(P_RE, 1'b1, 3'd2, 1'b1);
        chk("relock_note", int'(note), 2);

        // Reset while locked clears outputs without waiting for a clock.
        rst_n = 1'b0;
        #1;
        chk("async_note", int'(note), 0);
        chk("async_valid", int'(note_valid), 0);
        chk("async_chg", int'(note_chg), 0);
        chk("async_period", int'(period), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (TMO + 100) @(negedge clk);
        chk("post_rst_note", int'(note), 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_decoder.md
Name: tone_decoder

Overview:
- Receive-side counterpart of the PWM beep generator.
- Measures the period of an external square-wave tone input (another board's beep line, or a comparator-squared microphone signal) in system clocks.
- Classifies each period against the same seven-note table (DO..XI).
- Reports a stable note code once several consecutive periods agree. Drives LED/segment display logic or a loopback self-test of the beep path.

Parameters:
- DO, 16'd47750, full tone period in clk cycles for note 1
- RE, 16'd42250, note 2
- MI, 16'd37900, note 3
- FA, 16'd37550, note 4
- SO, 16'd31850, note 5
- LA, 16'd28400, note 6
- XI, 16'd25400, note 7
- TOL, 16'd150, match tolerance; must be < 175 (half the MI/FA spacing)
- LOCK_CNT, 3'd4, consecutive matching periods required to lock
- TIMEOUT, 17'd100000, cycles without a rising edge before declaring silence (2 ms at 50 MHz)

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- tone_in  input  1  asynchronous square-wave tone
- note  output  3  0 = none, 1..7 = DO..XI
- note_valid  output  1  high while locked
- note_chg  output  1  one-cycle pulse whenever note changes (including to 0)
- period  output  17  last measured period, debug

Behaviour:
- Reset (async, rst_n low): note=0, note_valid=0, note_chg=0, period=0, counter=0, candidate=0, match count=0, state IDLE, synchronizer flops=0.
- Input path: 2-FF synchronizer, then registered rising-edge detect. The edge pulse asserts 3 clk after tone_in rises (±1 clk sampling).
- Period counter (17 bits): cleared on the edge cycle, +1 per clk, saturates at TIMEOUT.
- Measured period = clk cycles between consecutive edge pulses. It is latched into `period` on the second and later edges.
- Classify: code c = k if |period - NOTE_k| <= TOL, else 0. Windows are disjoint for legal TOL; if they overlap, the lowest k wins. Use 17-bit unsigned compare, no signed arithmetic.
- All outputs are registered and update 1 clk after the edge or timeout cycle.
- States:
  - IDLE: counter not valid. On edge -> ACQUIRE with cand=0, mcnt=0 (first edge only starts timing).
  - ACQUIRE, on edge:
    - c==0: cand=0, mcnt=0.
    - c==cand: mcnt+1. When mcnt reaches LOCK_CNT -> LOCKED, note=c, note_valid=1, note_chg pulse.
    - otherwise: cand=c, mcnt=1.
  - LOCKED, on edge:
    - c==note: stay.
    - otherwise: note=0, note_valid=0, note_chg pulse, -> ACQUIRE with cand=c, mcnt=(c!=0).
- Timeout: counter reaches TIMEOUT in ACQUIRE or LOCKED -> IDLE, cand=0, mcnt=0. If it was LOCKED, note=0, note_valid=0, note_chg pulse.
- Edge and timeout in the same cycle: the edge wins. The period equals TIMEOUT, which classifies to 0.
- note_chg never pulses on a no-change event, and never pulses on two consecutive cycles.
- Reset asserted mid-lock: outputs clear immediately. No note_chg pulse after release.

Test Plan:
- DO tone: 5 rising edges spaced 47750 clk (4 periods) -> note=1, note_valid=1, one note_chg pulse ~4 clk after the 5th tone_in edge; no output change after edges 1–4.
- Tolerance: periods of 47900 lock note=1. Periods of 47901 never lock, note stays 0. Same check at 47600/47599.
- MI/FA separation: 37550 -> note=4; 37900 -> note=3; 37725 (175 from both) -> note stays 0, note_valid=0.
- Note switch: locked on SO (31850), then LA periods (28400) -> note 0 with a chg pulse 1 clk after the first LA-period edge; note=6 with a second chg pulse after the 4th LA period.
- Silence: locked on XI, tone_in held low -> note=0, note_valid=0, single chg pulse 100000 clk (+pipeline) after the last edge; state IDLE, and the next edge does not update period.
- Glitch/reset: one 1000-clk period inside a locked RE stream -> immediate unlock, relock after 4 RE periods. rst_n low mid-lock -> all outputs 0 asynchronously.
